// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: stepped frequency sweep sequencer for the NCO core.
// Accepts a start/stop/step/dwell descriptor, drives phi_inc_o through each
// point, waits out the NCO latency, then flags settled for the dwell time.
module nco_sweep_ctrl #(
    parameter int APR = 32,
    parameter int LAT = 9,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [APR-1:0] cfg_start,
    input  logic [APR-1:0] cfg_stop,
    input  logic [APR-1:0] cfg_step,
    input  logic [CW-1:0]  cfg_dwell,
    input  logic           cfg_cont,
    input  logic           abort,
    output logic [APR-1:0] phi_inc_o,
    output logic           busy,
    output logic           settled,
    output logic           done
);

    // The shared counter must hold both LAT-1 and the largest dwell reload.
    localparam int LW = $clog2(LAT + 1);
    localparam int NW = (CW > LW) ? CW : LW;
    localparam logic [NW-1:0] LAT_LOAD = NW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [APR-1:0]  phi_q, phi_d;

    logic [APR-1:0]  start_q, stop_q, step_q;
    logic [CW-1:0]   dwell_q;
    logic            cont_q;

    logic            accept;
    logic [APR:0]    nxt;
    logic            last;

    // Next sweep point, one bit wider so a wrap past the top is visible.
    function automatic logic [APR:0] sweep_next(input logic [APR-1:0] cur,
                                                input logic [APR-1:0] inc);
        return {1'b0, cur} + {1'b0, inc};
    endfunction

    // Dwell reload value; a dwell of zero still holds the point for one tick.
    function automatic logic [NW-1:0] dwell_load(input logic [CW-1:0] d);
        logic [NW-1:0] w;
        w = NW'(d);
        return (d == '0) ? '0 : (w - NW'(1));
    endfunction

    assign cfg_ready = (state_q == S_IDLE) & ~abort;
    assign accept    = cfg_valid & cfg_ready;
    assign nxt       = sweep_next(phi_q, step_q);
    assign last      = (step_q == '0) | nxt[APR] | (nxt[APR-1:0] > stop_q);

    assign phi_inc_o = phi_q;
    assign busy      = (state_q != S_IDLE);
    assign settled   = (state_q == S_DWELL);
    assign done      = (state_q == S_DONE);

    // Descriptor capture on handshake; only meaningful while a sweep runs.
    always_ff @(posedge clk) begin
        if (accept) begin
            start_q <= cfg_start;
            stop_q  <= cfg_stop;
            step_q  <= cfg_step;
            dwell_q <= cfg_dwell;
            cont_q  <= cfg_cont;
        end
    end

    // State, shared settle/dwell counter and output phase increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
        end
    end

    // Sweep sequencing; abort wins over any clken-qualified progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    phi_d   = cfg_start;
                    cnt_d   = LAT_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (clken) begin
                    if (cnt_q == '0) begin
                        state_d = S_DWELL;
                        cnt_d   = dwell_load(dwell_q);
                    end else begin
                        cnt_d = cnt_q - NW'(1);
                    end
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (clken) begin
                    if (cnt_q == '0) begin
                        if (!last) begin
                            phi_d   = nxt[APR-1:0];
                            cnt_d   = LAT_LOAD;
                            state_d = S_SETTLE;
                        end else if (cont_q) begin
                            phi_d   = start_q;
                            cnt_d   = LAT_LOAD;
                            state_d = S_SETTLE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - NW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed sweeps checked every cycle against a
// tick-budget model, plus literal point lists and pulse counts per scenario.
module tb_nco_sweep_ctrl;

    localparam int APR = 32;
    localparam int LAT = 9;
    localparam int CW  = 16;

    logic            clk;
    logic            reset;
    logic            clken;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [APR-1:0]  cfg_start, cfg_stop, cfg_step;
    logic [CW-1:0]   cfg_dwell;
    logic            cfg_cont;
    logic            abort;
    logic [APR-1:0]  phi_inc_o;
    logic            busy, settled, done;

    nco_sweep_ctrl #(.APR(APR), .LAT(LAT), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_cont  (cfg_cont),
        .abort     (abort),
        .phi_inc_o (phi_inc_o),
        .busy      (busy),
        .settled   (settled),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: busy flag, phase (1 settle, 2 dwell, 3 done), clken ticks left.
    logic   mb   = 1'b0;
    int     mph  = 0;
    int     mleft = 0;
    longint mval = 0;
    longint mstart = 0, mstop = 0, mstep = 0, mdwell = 0;
    logic   mcont = 1'b0;

    always @(posedge clk or posedge reset) begin
        longint nx;
        logic   lst;
        if (reset) begin
            mb   <= 1'b0;
            mph  <= 0;
            mval <= 0;
        end else if (!mb) begin
            if (cfg_valid && !abort) begin
                mb     <= 1'b1;
                mph    <= 1;
                mleft  <= LAT;
                mval   <= longint'(cfg_start);
                mstart <= longint'(cfg_start);
                mstop  <= longint'(cfg_stop);
                mstep  <= longint'(cfg_step);
                mdwell <= longint'(cfg_dwell);
                mcont  <= cfg_cont;
            end
        end else if (abort || mph == 3) begin
            mb  <= 1'b0;
            mph <= 0;
        end else if (clken) begin
            if (mleft > 1) begin
                mleft <= mleft - 1;
            end else if (mph == 1) begin
                mph   <= 2;
                mleft <= (mdwell == 0) ? 1 : int'(mdwell);
            end else begin
                nx  = mval + mstep;
                lst = (mstep == 0) || (nx > 64'hFFFF_FFFF) || (nx > mstop);
                if (!lst) begin
                    mval <= nx; mph <= 1; mleft <= LAT;
                end else if (mcont) begin
                    mval <= mstart; mph <= 1; mleft <= LAT;
                end else begin
                    mph <= 3;
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;
    logic tog = 1'b0;
    logic prev_set = 1'b0;
    logic [APR-1:0] pts[$];
    int nset  = 0;
    int ndone = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One clock: compare at the falling edge, gather stats, then drive clken.
    task automatic tick();
        @(negedge clk);
        chk("phi_inc_o", longint'(phi_inc_o), mval & 64'hFFFF_FFFF);
        chk("busy",      longint'(busy),      longint'(mb));
        chk("settled",   longint'(settled),   longint'(mb && mph == 2));
        chk("done",      longint'(done),      longint'(mb && mph == 3));
        chk("cfg_ready", longint'(cfg_ready), longint'(!mb && !abort));
        if (settled && !prev_set) pts.push_back(phi_inc_o);
        if (settled) nset++;
        if (done) ndone++;
        prev_set = settled;
        #1;
        clken = tog ? ~clken : 1'b1;
    endtask

    task automatic send(input logic [APR-1:0] s, input logic [APR-1:0] p,
                        input logic [APR-1:0] st, input logic [CW-1:0] d,
                        input logic c);
        int n;
        cfg_start = s; cfg_stop = p; cfg_step = st; cfg_dwell = d; cfg_cont = c;
        cfg_valid = 1'b1;
        #1;
        n = 0;
        while (!cfg_ready && n < 300) begin
            tick();
            #1;
            n++;
        end
        chk("accept_ready", longint'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        chk("idle_reached", longint'(busy), 0);
    endtask

    task automatic wait_pts(input int want, input int lim);
        int n;
        n = 0;
        while (pts.size() < want && n < lim) begin
            tick();
            n++;
        end
        chk("points_reached", longint'(pts.size() >= want), 1);
    endtask

    int b, s0, d0;

    initial begin
        reset = 1'b1; clken = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_cont = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_ready", longint'(cfg_ready), 1);
        chk("rst_phi",   longint'(phi_inc_o), 0);
        chk("rst_busy",  longint'(busy), 0);
        tick();

        // Single pass 100..400 step 100, dwell 3.
        b = pts.size(); s0 = nset; d0 = ndone;
        send(32'd100, 32'd400, 32'd100, 16'd3, 1'b0);
        wait_idle(200);
        chk("t1_npts", pts.size() - b, 4);
        chk("t1_p0", longint'(pts[b]),   100);
        chk("t1_p1", longint'(pts[b+1]), 200);
        chk("t1_p2", longint'(pts[b+2]), 300);
        chk("t1_p3", longint'(pts[b+3]), 400);
        chk("t1_settled_cycles", nset - s0, 12);
        chk("t1_done_pulses", ndone - d0, 1);
        tick();

        // Continuous: wraps back to start, never done; stopped by abort.
        b = pts.size(); d0 = ndone;
        send(32'd100, 32'd400, 32'd100, 16'd3, 1'b1);
        wait_pts(b + 5, 300);
        chk("t2_p3", longint'(pts[b+3]), 400);
        chk("t2_wrap", longint'(pts[b+4]), 100);
        abort = 1'b1;
        tick();
        chk("t2_abort_busy", longint'(busy), 0);
        abort = 1'b0;
        tick();
        chk("t2_done_pulses", ndone - d0, 0);

        // Overflow of the increment ends the sweep.
        b = pts.size(); d0 = ndone;
        send(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd2, 1'b0);
        wait_idle(200);
        chk("t3_npts", pts.size() - b, 2);
        chk("t3_p0", longint'(pts[b]),   64'hFFFF_FF00);
        chk("t3_p1", longint'(pts[b+1]), 64'hFFFF_FF80);
        chk("t3_done_pulses", ndone - d0, 1);
        tick();

        // clken toggling halves progress; values unchanged.
        b = pts.size(); s0 = nset; d0 = ndone;
        tog = 1'b1;
        send(32'd100, 32'd400, 32'd100, 16'd3, 1'b0);
        wait_idle(400);
        tog = 1'b0;
        chk("t4_npts", pts.size() - b, 4);
        chk("t4_p3", longint'(pts[b+3]), 400);
        chk("t4_settled_cycles", nset - s0, 24);
        chk("t4_done_pulses", ndone - d0, 1);
        tick();

        // Abort during the second dwell.
        b = pts.size(); d0 = ndone;
        send(32'd100, 32'd400, 32'd100, 16'd3, 1'b0);
        wait_pts(b + 2, 100);
        chk("t5_p1", longint'(pts[b+1]), 200);
        abort = 1'b1;
        tick();
        chk("t5_busy", longint'(busy), 0);
        chk("t5_settled", longint'(settled), 0);
        chk("t5_phi_held", longint'(phi_inc_o), 200);
        chk("t5_ready_blocked", longint'(cfg_ready), 0);
        tick();
        abort = 1'b0;
        #1;
        chk("t5_ready_back", longint'(cfg_ready), 1);
        chk("t5_done_pulses", ndone - d0, 0);
        tick();

        // dwell=0, step=0: one point held one clk; second descriptor waits.
        b = pts.size(); s0 = nset; d0 = ndone;
        send(32'd7, 32'd1000, 32'd0, 16'd0, 1'b0);
        cfg_start = 32'd555; cfg_stop = 32'd555; cfg_step = 32'd0; cfg_dwell = 16'd0;
        cfg_valid = 1'b1;
        wait_pts(b + 2, 100);
        cfg_valid = 1'b0;
        wait_idle(50);
        chk("t6_npts", pts.size() - b, 2);
        chk("t6_p0", longint'(pts[b]),   7);
        chk("t6_p1", longint'(pts[b+1]), 555);
        chk("t6_settled_cycles", nset - s0, 2);
        chk("t6_done_pulses", ndone - d0, 2);
        tick();

        // Start above stop: one point, then done.
        b = pts.size(); d0 = ndone;
        send(32'd500, 32'd100, 32'd50, 16'd1, 1'b0);
        wait_idle(100);
        chk("t7_npts", pts.size() - b, 1);
        chk("t7_p0", longint'(pts[b]), 500);
        chk("t7_done_pulses", ndone - d0, 1);
        tick();

        // Asynchronous reset in the middle of a sweep.
        send(32'd100, 32'd400, 32'd100, 16'd3, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("t8_phi", longint'(phi_inc_o), 0);
        chk("t8_busy", longint'(busy), 0);
        chk("t8_settled", longint'(settled), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
